bin_to_bcd_seq: RTL and testbench

//   Sequential, parametrised binary-to-packed-BCD converter using the shift-add-3
//   (double-dabble) algorithm, with a Start/Busy/Done handshake.

---
 rtl/bin_to_bcd_seq.sv | 151 +++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-packed-BCD converter (shift-add-3), one bit per clock, with
// Start/Busy/Done handshake, overflow flag and a leading-zero blanking mask.
module bin_to_bcd_seq #(
  parameter int unsigned BIN_W  = 20,
  parameter int unsigned DIGITS = 7
) (
  input  logic                  Sys_CLK,
  input  logic                  Sys_RST,
  input  logic                  Start,
  input  logic [BIN_W-1:0]      Data_Bin,
  output logic                  Busy,
  output logic                  Done,
  output logic [4*DIGITS-1:0]   Data_BCD,
  output logic [DIGITS-1:0]     Digit_En,
  output logic                  Overflow
);

  localparam int unsigned CntW = $clog2(BIN_W + 1);
  localparam int unsigned BcdW = 4 * DIGITS;

  typedef enum logic [0:0] {StIdle, StConv} state_e;

  state_e            state_q, state_d;
  logic [BIN_W-1:0]  shift_q, shift_d;
  logic [BcdW-1:0]   scratch_q, scratch_d;
  logic              ovf_q, ovf_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic [DIGITS-1:0] en_q, en_d;
  logic              ovfo_q, ovfo_d;
  logic              done_q, done_d;

  logic              accept;
  logic              last;
  logic [BcdW-1:0]   adj;
  logic [BcdW-1:0]   step_scratch;
  logic [BIN_W-1:0]  step_shift;
  logic              step_carry;
  logic [DIGITS-1:0] en_final;
  logic              nz;

  assign accept = (state_q == StIdle) && Start;
  assign last   = (state_q == StConv) && (cnt_q == CntW'(1));

  // State register
  always_ff @(posedge Sys_CLK or posedge Sys_RST) begin
    if (Sys_RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (Start) state_d = StConv;
      StConv: if (cnt_q == CntW'(1)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    Busy = (state_q == StConv);
  end

  // Add-3 correction on every digit, 4-bit modulo
  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // A carry out of the top digit means the value no longer fits in DIGITS digits
  assign step_carry   = adj[BcdW-1];
  assign step_scratch = {adj[BcdW-2:0], shift_q[BIN_W-1]};
  assign step_shift   = {shift_q[BIN_W-2:0], 1'b0};

  // Digit i is lit when it or any more significant digit is non-zero
  always_comb begin
    en_final = '0;
    nz       = 1'b0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      nz          = nz | (|step_scratch[4*i +: 4]);
      en_final[i] = nz;
    end
    en_final[0] = 1'b1;
  end

  // Datapath next-state
  always_comb begin
    shift_d   = shift_q;
    scratch_d = scratch_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    en_d      = en_q;
    ovfo_d    = ovfo_q;
    done_d    = 1'b0;
    if (accept) begin
      shift_d   = Data_Bin;
      scratch_d = '0;
      ovf_d     = 1'b0;
      cnt_d     = CntW'(BIN_W);
    end else if (state_q == StConv) begin
      shift_d   = step_shift;
      scratch_d = step_scratch;
      ovf_d     = ovf_q | step_carry;
      cnt_d     = cnt_q - CntW'(1);
      if (last) begin
        bcd_d  = step_scratch;
        en_d   = en_final;
        ovfo_d = ovf_q | step_carry;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Sys_CLK or posedge Sys_RST) begin
    if (Sys_RST) begin
      shift_q   <= '0;
      scratch_q <= '0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      en_q      <= DIGITS'(1);
      ovfo_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      en_q      <= en_d;
      ovfo_q    <= ovfo_d;
      done_q    <= done_d;
    end
  end

  assign Done     = done_q;
  assign Data_BCD = bcd_q;
  assign Digit_En = en_q;
  assign Overflow = ovfo_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Randomised self-checking bench for bin_to_bcd_seq: a 20-bit/7-digit and an
// 11-bit/3-digit instance checked against a decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst;
  logic        start_a, busy_a, done_a, ovf_a;
  logic [19:0] bin_a;
  logic [27:0] bcd_a;
  logic [6:0]  en_a;
  logic        start_b, busy_b, done_b, ovf_b;
  logic [10:0] bin_b;
  logic [11:0] bcd_b;
  logic [2:0]  en_b;

  int unsigned n_cmp;
  int unsigned n_err;

  bin_to_bcd_seq #(.BIN_W(20), .DIGITS(7)) u_dut_a (
    .Sys_CLK  (clk),
    .Sys_RST  (rst),
    .Start    (start_a),
    .Data_Bin (bin_a),
    .Busy     (busy_a),
    .Done     (done_a),
    .Data_BCD (bcd_a),
    .Digit_En (en_a),
    .Overflow (ovf_a)
  );

  bin_to_bcd_seq #(.BIN_W(11), .DIGITS(3)) u_dut_b (
    .Sys_CLK  (clk),
    .Sys_RST  (rst),
    .Start    (start_b),
    .Data_Bin (bin_b),
    .Busy     (busy_b),
    .Done     (done_b),
    .Data_BCD (bcd_b),
    .Digit_En (en_b),
    .Overflow (ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned pow10(input int unsigned d);
    longint unsigned p = 1;
    for (int i = 0; i < int'(d); i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [63:0] ref_bcd(input longint unsigned v, input int unsigned d);
    longint unsigned m = v % pow10(d);
    logic [63:0] r = '0;
    for (int i = 0; i < int'(d); i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic [63:0] ref_en(input longint unsigned v, input int unsigned d);
    longint unsigned m = v % pow10(d);
    logic [63:0] r = '0;
    for (int i = 0; i < int'(d); i++) r[i] = (i == 0) || (m >= pow10(i));
    return r;
  endfunction

  function automatic logic [63:0] ref_ovf(input longint unsigned v, input int unsigned d);
    return {63'd0, (v >= pow10(d))};
  endfunction

  // Full conversion on instance A with timing check, a stray Start mid-flight and Data_Bin noise
  task automatic conv_a(input logic [19:0] v, input string tag);
    logic [27:0] hold;
    int unsigned bad;
    @(negedge clk);
    hold    = bcd_a;
    start_a = 1'b1;
    bin_a   = v;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    bin_a   = 20'($urandom);
    bad     = 0;
    for (int j = 0; j <= 20; j++) begin
      @(negedge clk);
      if (busy_a !== (j < 20)) bad++;
      if (done_a !== (j == 20)) bad++;
      if (j < 20 && bcd_a !== hold) bad++;
      bin_a = 20'($urandom);
      if (j == 4) begin
        start_a = 1'b1;
        bin_a   = 20'd777;
      end
      if (j == 5) start_a = 1'b0;
    end
    check({tag, ":timing"}, 64'(bad), 64'd0);
    check({tag, ":bcd"}, 64'(bcd_a), ref_bcd(64'(v), 7));
    check({tag, ":en"}, 64'(en_a), ref_en(64'(v), 7));
    check({tag, ":ovf"}, 64'(ovf_a), ref_ovf(64'(v), 7));
    @(negedge clk);
    check({tag, ":done_clr"}, 64'(done_a), 64'd0);
  endtask

  task automatic conv_b(input logic [10:0] v, input string tag);
    int unsigned bad;
    @(negedge clk);
    start_b = 1'b1;
    bin_b   = v;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    bad     = 0;
    for (int j = 0; j <= 11; j++) begin
      @(negedge clk);
      if (busy_b !== (j < 11)) bad++;
      if (done_b !== (j == 11)) bad++;
      bin_b = 11'($urandom);
    end
    check({tag, ":timing"}, 64'(bad), 64'd0);
    check({tag, ":bcd"}, 64'(bcd_b), ref_bcd(64'(v), 3));
    check({tag, ":en"}, 64'(en_b), ref_en(64'(v), 3));
    check({tag, ":ovf"}, 64'(ovf_b), ref_ovf(64'(v), 3));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ":a_busy"}, 64'(busy_a), 64'd0);
    check({tag, ":a_done"}, 64'(done_a), 64'd0);
    check({tag, ":a_bcd"}, 64'(bcd_a), 64'd0);
    check({tag, ":a_en"}, 64'(en_a), 64'd1);
    check({tag, ":a_ovf"}, 64'(ovf_a), 64'd0);
    check({tag, ":b_bcd"}, 64'(bcd_b), 64'd0);
    check({tag, ":b_en"}, 64'(en_b), 64'd1);
  endtask

  initial begin
    logic [19:0] v1, v2;
    int unsigned bad, dones;
    n_cmp   = 0;
    n_err   = 0;
    rst     = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    bin_a   = '0;
    bin_b   = '0;

    // Reset asserted between clock edges must act immediately
    #3 rst = 1'b1;
    #1 check_reset_outputs("rst_async");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    conv_a(20'd1234, "d1234");
    check("d1234:exact", 64'(bcd_a), 64'h0001234);
    conv_a(20'hFFFFF, "max");
    check("max:exact", 64'(bcd_a), 64'h1048575);
    check("max:en7f", 64'(en_a), 64'h7F);
    conv_a(20'd0, "zero");
    check("zero:en", 64'(en_a), 64'b0000001);
    conv_a(20'd905, "d905");
    check("d905:en", 64'(en_a), 64'b0000111);
    conv_a(20'd500, "d500");
    check("d500:exact", 64'(bcd_a), 64'h0000500);

    // Start held high through Done: next operand accepted one edge after Done
    v1 = 20'($urandom);
    v2 = 20'($urandom);
    @(negedge clk);
    start_a = 1'b1;
    bin_a   = v1;
    @(posedge clk);
    bad = 0;
    for (int j = 0; j <= 41; j++) begin
      @(negedge clk);
      if (j == 20) begin
        check("b2b:first", 64'(bcd_a), ref_bcd(64'(v1), 7));
        if (done_a !== 1'b1 || busy_a !== 1'b0) bad++;
        bin_a = v2;
      end else if (j == 21) begin
        if (busy_a !== 1'b1 || done_a !== 1'b0) bad++;
        start_a = 1'b0;
        bin_a   = 20'($urandom);
      end else if (j == 41) begin
        if (done_a !== 1'b1) bad++;
        check("b2b:second", 64'(bcd_a), ref_bcd(64'(v2), 7));
      end else if (done_a !== 1'b0) begin
        bad++;
      end
    end
    check("b2b:timing", 64'(bad), 64'd0);

    for (int n = 0; n < 30; n++) conv_a(20'($urandom), "rand_a");

    conv_b(11'd999, "b999");
    check("b999:exact", 64'(bcd_b), 64'h999);
    conv_b(11'd1234, "b1234");
    check("b1234:exact", 64'(bcd_b), 64'h234);
    check("b1234:ovf", 64'(ovf_b), 64'd1);
    conv_b(11'd2047, "b2047");
    check("b2047:exact", 64'(bcd_b), 64'h047);
    check("b2047:en", 64'(en_b), 64'b011);
    for (int n = 0; n < 20; n++) conv_b(11'($urandom_range(0, 2047)), "rand_b");

    // Reset in the middle of a conversion aborts it
    @(negedge clk);
    start_a = 1'b1;
    bin_a   = 20'd65535;
    @(posedge clk);
    #1 start_a = 1'b0;
    repeat (9) @(negedge clk);
    #1 rst = 1'b1;
    #1 check_reset_outputs("rst_mid");
    @(negedge clk);
    rst   = 1'b0;
    dones = 0;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      if (done_a !== 1'b0 || busy_a !== 1'b0) dones++;
    end
    check("rst_mid:no_done", 64'(dones), 64'd0);
    conv_a(20'd65535, "after_rst");
    check("after_rst:exact", 64'(bcd_a), 64'h0065535);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
